// File: rtl/calc_seq_engine_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the sequential BCD calculator core:
//   - opcode encodings (OP_ADD .. OP_MOD); every other code is invalid
//   - FSM state encoding for calc_seq_engine
//   - digits_to_bits(): binary width needed to hold 10^digits - 1
// -----------------------------------------------------------------------------
package calc_pkg;

   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_SUB = 3'b010;
   localparam logic [2:0] OP_MUL = 3'b011;
   localparam logic [2:0] OP_DIV = 3'b100;
   localparam logic [2:0] OP_MOD = 3'b101;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      EXEC = 3'd2,
      CONV = 3'd3,
      DONE = 3'd4
   } state_t;

   // Bits needed for the largest value of 'digits' decimal digits.
   // clog2(10^d) works because 10^d is never a power of two for d >= 1.
   function automatic int digits_to_bits(input int digits);
      int maxv;
      maxv = 1;
      for (int i = 0; i < digits; i++) maxv = maxv * 10;
      return $clog2(maxv);
   endfunction

endpackage

// File: rtl/calc_seq_engine_if.sv
// -----------------------------------------------------------------------------
// calc_seq_engine_if
// Handshake and data bundle between the operand-entry side (master) and the
// calculator core (slave).
//   start       master->slave  request, sampled by the core only when idle
//   op          master->slave  3-bit opcode
//   a_bcd/b_bcd master->slave  packed BCD operands, digit 0 in the LSBs
//   busy        slave->master  operation in flight
//   done        slave->master  one-cycle pulse, result/err/neg valid
//   err         slave->master  bad digit, bad opcode or division by zero
//   neg         slave->master  sign of a subtraction result
//   result_bcd  slave->master  packed BCD result, 2*DIGITS digits
// DIGITS must match the DIGITS parameter of the attached core.
// -----------------------------------------------------------------------------
interface calc_seq_engine_if #(
   parameter int DIGITS = 2
);
   localparam int RES_DIGITS = 2 * DIGITS;

   logic                      start;
   logic [2:0]                op;
   logic [4*DIGITS-1:0]       a_bcd;
   logic [4*DIGITS-1:0]       b_bcd;
   logic                      busy;
   logic                      done;
   logic                      err;
   logic                      neg;
   logic [4*RES_DIGITS-1:0]   result_bcd;

   modport master (
      output start, op, a_bcd, b_bcd,
      input  busy, done, err, neg, result_bcd
   );

   modport slave (
      input  start, op, a_bcd, b_bcd,
      output busy, done, err, neg, result_bcd
   );

endinterface

// File: rtl/calc_seq_engine_bin2bcd.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Serial double-dabble converter: one bit per clock, exactly RW shift cycles
// after the load.
//   clk, reset  clock and asynchronous active-high reset
//   start       load 'bin' and clear the BCD accumulator (one-cycle pulse)
//   bin         RW-bit binary value, sampled on the start edge
//   bcd         ND packed BCD digits; final once the done cycle has passed
//   done        high during the cycle whose edge performs the last shift
// Values that need more than ND digits lose their top digit(s); the caller
// sizes ND so that this cannot happen for its operand range.
// -----------------------------------------------------------------------------
module bin2bcd_seq #(
   parameter int RW = 14,
   parameter int ND = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [RW-1:0]     bin,
   output logic [4*ND-1:0]   bcd,
   output logic              done
);

   localparam int CW = $clog2(RW);

   logic [RW-1:0]    sh;
   logic [4*ND-1:0]  bcd_q;
   logic [4*ND-1:0]  adj;
   logic [CW-1:0]    cnt;
   logic             active;

   // Add 3 to every digit >= 5 so the following shift carries correctly.
   always_comb begin
      adj = bcd_q;
      for (int i = 0; i < ND; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sh     <= '0;
         bcd_q  <= '0;
         cnt    <= '0;
         active <= 1'b0;
      end else if (start) begin
         sh     <= bin;
         bcd_q  <= '0;
         cnt    <= '0;
         active <= 1'b1;
      end else if (active) begin
         {bcd_q, sh} <= {adj[4*ND-2:0], sh, 1'b0};
         cnt         <= cnt + CW'(1);
         if (cnt == CW'(RW-1)) active <= 1'b0;
      end
   end

   assign done = active && (cnt == CW'(RW-1));
   assign bcd  = bcd_q;

endmodule

// File: rtl/calc_seq_engine.sv
// -----------------------------------------------------------------------------
// calc_seq_engine
// Sequential BCD arithmetic core. Two DIGITS-digit BCD operands are converted
// to binary, combined (add, |sub|, mul, div, mod) and the result converted
// back to 2*DIGITS BCD digits with a serial double-dabble.
//   clk    system clock
//   reset  asynchronous active-high reset; aborts any operation in flight
//   bus    calc_seq_engine_if.slave: start/op/a_bcd/b_bcd in,
//          busy/done/err/neg/result_bcd out
// Latency from the start-sampling edge to the edge raising done:
//   add/sub RW+3, mul/div/mod RW+OPW+3, any error 2.
// Build option: define SIGNED_SUB_EN to report the sign of A-B on neg;
// without it neg is constant 0 and sub returns |A-B|.
// -----------------------------------------------------------------------------
module calc_seq_engine
   import calc_pkg::*;
#(
   parameter int DIGITS = 2
) (
   input  logic              clk,
   input  logic              reset,
   calc_seq_engine_if.slave  bus
);

   localparam int RES_DIGITS = 2 * DIGITS;
   localparam int OPW        = digits_to_bits(DIGITS);
   localparam int RW         = 2 * OPW;
   localparam int CW         = $clog2(OPW + 1);

   state_t                   state;
   state_t                   next_state;

   logic [4*DIGITS-1:0]      a_bcd_q;
   logic [4*DIGITS-1:0]      b_bcd_q;
   logic [2:0]               op_q;

   logic [OPW-1:0]           a_bin;
   logic [OPW-1:0]           b_bin;
   logic                     err_q;

   logic [RW-1:0]            prod;
   logic [RW-1:0]            mcand;
   logic [OPW-1:0]           mplier;
   logic [OPW-1:0]           quo;
   logic [OPW:0]             rem;
   logic [CW-1:0]            cnt;

   logic                     done_q;
   logic                     err_o;
   logic [4*RES_DIGITS-1:0]  result_q;

   logic [OPW-1:0]           a_conv;
   logic [OPW-1:0]           b_conv;
   logic                     digits_ok;
   logic                     op_ok;
   logic                     load_err;
   logic [OPW:0]             rem_sh;
   logic                     div_ge;
   logic [RW-1:0]            exec_res;
   logic                     exec_last;
   logic                     busy_c;
   logic                     conv_start;
   logic [4*RES_DIGITS-1:0]  conv_bcd;
   logic                     conv_last;

`ifdef SIGNED_SUB_EN
   logic                     neg_q;
   logic                     neg_o;
`endif

   // |x - y| computed in signed arithmetic, zero-extended to RW bits.
   function automatic logic [RW-1:0] abs_diff(input logic [OPW-1:0] x,
                                              input logic [OPW-1:0] y);
      logic signed [OPW:0] d;
      d = $signed({1'b0, x}) - $signed({1'b0, y});
      if (d < 0) d = -d;
      return {{(RW-OPW-1){1'b0}}, d};
   endfunction

   // BCD to binary: multiply-by-10 accumulate from the most significant digit.
   always_comb begin
      a_conv    = '0;
      b_conv    = '0;
      digits_ok = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         if ((a_bcd_q[4*i +: 4] > 4'd9) || (b_bcd_q[4*i +: 4] > 4'd9)) digits_ok = 1'b0;
         a_conv = a_conv * OPW'(10) + OPW'(a_bcd_q[4*i +: 4]);
         b_conv = b_conv * OPW'(10) + OPW'(b_bcd_q[4*i +: 4]);
      end
   end

   assign op_ok    = (op_q >= OP_ADD) && (op_q <= OP_MOD);
   assign load_err = !digits_ok || !op_ok ||
                     (((op_q == OP_DIV) || (op_q == OP_MOD)) && (b_conv == '0));

   // Restoring division step: bring down the next dividend bit, subtract if it fits.
   assign rem_sh = {rem[OPW-1:0], quo[OPW-1]};
   assign div_ge = (rem_sh >= {1'b0, b_bin});

   // Add/sub finish in their single EXEC cycle; the iterative ops run OPW
   // steps and hand over their registered result on the following cycle.
   assign exec_last = (op_q == OP_ADD) || (op_q == OP_SUB) || (cnt == CW'(OPW));

   always_comb begin
      exec_res = '0;
      case (op_q)
         OP_ADD:  exec_res = {{OPW{1'b0}}, a_bin} + {{OPW{1'b0}}, b_bin};
         OP_SUB:  exec_res = abs_diff(a_bin, b_bin);
         OP_MUL:  exec_res = prod;
         OP_DIV:  exec_res = {{OPW{1'b0}}, quo};
         OP_MOD:  exec_res = {{(RW-OPW-1){1'b0}}, rem};
         default: exec_res = '0;
      endcase
   end

   // ---- FSM: state register ----
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   // ---- FSM: next-state logic ----
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (bus.start) next_state = LOAD;
         LOAD:    next_state = load_err ? DONE : EXEC;
         EXEC:    if (exec_last) next_state = CONV;
         CONV:    if (conv_last) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // ---- FSM: outputs ----
   always_comb begin
      busy_c     = 1'b0;
      conv_start = 1'b0;
      case (state)
         IDLE:    busy_c = 1'b0;
         EXEC: begin
            busy_c     = 1'b1;
            conv_start = exec_last;
         end
         default: busy_c = 1'b1;
      endcase
   end

   // ---- Datapath and result registers ----
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_bcd_q  <= '0;
         b_bcd_q  <= '0;
         op_q     <= '0;
         a_bin    <= '0;
         b_bin    <= '0;
         err_q    <= 1'b0;
         prod     <= '0;
         mcand    <= '0;
         mplier   <= '0;
         quo      <= '0;
         rem      <= '0;
         cnt      <= '0;
         done_q   <= 1'b0;
         err_o    <= 1'b0;
         result_q <= '0;
`ifdef SIGNED_SUB_EN
         neg_q    <= 1'b0;
         neg_o    <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  a_bcd_q <= bus.a_bcd;
                  b_bcd_q <= bus.b_bcd;
                  op_q    <= bus.op;
               end
            end
            LOAD: begin
               a_bin  <= a_conv;
               b_bin  <= b_conv;
               err_q  <= load_err;
               prod   <= '0;
               mcand  <= {{OPW{1'b0}}, a_conv};
               mplier <= b_conv;
               quo    <= a_conv;
               rem    <= '0;
               cnt    <= '0;
`ifdef SIGNED_SUB_EN
               neg_q  <= 1'b0;
`endif
            end
            EXEC: begin
`ifdef SIGNED_SUB_EN
               if (op_q == OP_SUB) neg_q <= (b_bin > a_bin);
`endif
               if (!exec_last) begin
                  // Shift-add multiply and restoring divide advance together;
                  // only the one matching op_q is selected into exec_res.
                  if (mplier[0]) prod <= prod + mcand;
                  mcand  <= mcand << 1;
                  mplier <= mplier >> 1;
                  if (div_ge) begin
                     rem <= rem_sh - {1'b0, b_bin};
                     quo <= {quo[OPW-2:0], 1'b1};
                  end else begin
                     rem <= rem_sh;
                     quo <= {quo[OPW-2:0], 1'b0};
                  end
                  cnt <= cnt + CW'(1);
               end
            end
            DONE: begin
               done_q   <= 1'b1;
               err_o    <= err_q;
               result_q <= err_q ? '0 : conv_bcd;
`ifdef SIGNED_SUB_EN
               neg_o    <= neg_q;
`endif
            end
            default: ;
         endcase
      end
   end

   bin2bcd_seq #(
      .RW (RW),
      .ND (RES_DIGITS)
   ) u_bin2bcd (
      .clk   (clk),
      .reset (reset),
      .start (conv_start),
      .bin   (exec_res),
      .bcd   (conv_bcd),
      .done  (conv_last)
   );

   assign bus.busy       = busy_c;
   assign bus.done       = done_q;
   assign bus.err        = err_o;
   assign bus.result_bcd = result_q;
`ifdef SIGNED_SUB_EN
   assign bus.neg        = neg_o;
`else
   assign bus.neg        = 1'b0;
`endif

endmodule

// File: tb/tb_calc_seq_engine.sv
module tb_calc_seq_engine;
   import calc_pkg::*;

`ifdef SIGNED_SUB_EN
   localparam logic SGN = 1'b1;
`else
   localparam logic SGN = 1'b0;
`endif

   localparam int LAT_AS  = 17;   // add/sub, DIGITS=2: RW+3
   localparam int LAT_MDM = 24;   // mul/div/mod, DIGITS=2: RW+OPW+3
   localparam int LAT_ERR = 2;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   calc_seq_engine_if #(.DIGITS(2)) bus ();
   calc_seq_engine_if #(.DIGITS(3)) bus3 ();

   calc_seq_engine #(.DIGITS(2)) dut  (.clk(clk), .reset(reset), .bus(bus));
   calc_seq_engine #(.DIGITS(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

   int cyc = 0;
   int checks = 0;
   int failures = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [15:0] res;
      logic        err;
      logic        neg;
      int          lat;
      int          t0;
      string       name;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   logic prev_busy = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Scoreboard monitor: every done pulse consumes one expected entry.
   always @(negedge clk) begin
      if (bus.done === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done: actual=done required=no_done result=%0h", bus.result_bcd);
         end else begin
            mon_e = sb.pop_front();
            chk({mon_e.name, ".result"}, 32'(bus.result_bcd), 32'(mon_e.res));
            chk({mon_e.name, ".err"}, 32'(bus.err), 32'(mon_e.err));
            chk({mon_e.name, ".neg"}, 32'(bus.neg), 32'(mon_e.neg));
            chk({mon_e.name, ".latency"}, 32'(cyc - mon_e.t0), 32'(mon_e.lat));
            chk({mon_e.name, ".busy_before"}, 32'(prev_busy), 32'd1);
            chk({mon_e.name, ".busy_at_done"}, 32'(bus.busy), 32'd0);
         end
      end
      prev_busy = bus.busy;
   end

   task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                        input logic [15:0] res, input logic e, input logic n,
                        input int lat, input string name);
      exp_t x;
      @(negedge clk);
      bus.a_bcd = a;
      bus.b_bcd = b;
      bus.op    = op;
      bus.start = 1'b1;
      x.res = res; x.err = e; x.neg = n; x.lat = lat; x.t0 = cyc + 1; x.name = name;
      sb.push_back(x);
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((sb.size() != 0 || bus.busy !== 1'b0) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout: actual=pending %0d required=0", sb.size());
         sb.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int t;
      int n;
      reset      = 1'b1;
      bus.start  = 1'b0;
      bus.op     = 3'b000;
      bus.a_bcd  = '0;
      bus.b_bcd  = '0;
      bus3.start = 1'b0;
      bus3.op    = 3'b000;
      bus3.a_bcd = '0;
      bus3.b_bcd = '0;
      repeat (3) @(negedge clk);
      chk("reset.busy", 32'(bus.busy), 32'd0);
      chk("reset.done", 32'(bus.done), 32'd0);
      chk("reset.err", 32'(bus.err), 32'd0);
      chk("reset.neg", 32'(bus.neg), 32'd0);
      chk("reset.result", 32'(bus.result_bcd), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // Main function, several patterns
      issue(8'h47, 8'h58, OP_ADD, 16'h0105, 1'b0, 1'b0, LAT_AS, "add_47_58");
      chk("add.busy_after_start", 32'(bus.busy), 32'd1);
      drain();
      issue(8'h23, 8'h58, OP_SUB, 16'h0035, 1'b0, SGN,  LAT_AS,  "sub_23_58");   drain();
      issue(8'h58, 8'h23, OP_SUB, 16'h0035, 1'b0, 1'b0, LAT_AS,  "sub_58_23");   drain();
      issue(8'h05, 8'h05, OP_SUB, 16'h0000, 1'b0, 1'b0, LAT_AS,  "sub_05_05");   drain();
      issue(8'h99, 8'h99, OP_ADD, 16'h0198, 1'b0, 1'b0, LAT_AS,  "add_99_99");   drain();
      issue(8'h00, 8'h00, OP_ADD, 16'h0000, 1'b0, 1'b0, LAT_AS,  "add_00_00");   drain();
      issue(8'h99, 8'h99, OP_MUL, 16'h9801, 1'b0, 1'b0, LAT_MDM, "mul_99_99");   drain();
      issue(8'h00, 8'h57, OP_MUL, 16'h0000, 1'b0, 1'b0, LAT_MDM, "mul_00_57");   drain();
      issue(8'h97, 8'h07, OP_DIV, 16'h0013, 1'b0, 1'b0, LAT_MDM, "div_97_07");   drain();
      issue(8'h97, 8'h07, OP_MOD, 16'h0006, 1'b0, 1'b0, LAT_MDM, "mod_97_07");   drain();
      issue(8'h05, 8'h09, OP_DIV, 16'h0000, 1'b0, 1'b0, LAT_MDM, "div_05_09");   drain();
      issue(8'h05, 8'h09, OP_MOD, 16'h0005, 1'b0, 1'b0, LAT_MDM, "mod_05_09");   drain();

      // Error cases
      issue(8'h12, 8'h00, OP_DIV, 16'h0000, 1'b1, 1'b0, LAT_ERR, "div_by_zero"); drain();
      issue(8'h12, 8'h00, OP_MOD, 16'h0000, 1'b1, 1'b0, LAT_ERR, "mod_by_zero"); drain();
      issue(8'h1A, 8'h05, OP_ADD, 16'h0000, 1'b1, 1'b0, LAT_ERR, "bad_digit");   drain();
      issue(8'h12, 8'h34, 3'b111, 16'h0000, 1'b1, 1'b0, LAT_ERR, "bad_op_111");  drain();
      issue(8'h12, 8'h34, 3'b000, 16'h0000, 1'b1, 1'b0, LAT_ERR, "bad_op_000");  drain();

      // Start pulses while busy are ignored: exactly one done
      issue(8'h11, 8'h22, OP_ADD, 16'h0033, 1'b0, 1'b0, LAT_AS, "ignore_busy");
      repeat (3) @(negedge clk);
      bus.a_bcd = 8'h44; bus.b_bcd = 8'h44; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      drain();
      repeat (5) @(negedge clk);
      chk("ignore_busy.result_held", 32'(bus.result_bcd), 32'h0033);

      // Start held high: second run accepted one idle cycle after done
      @(negedge clk);
      bus.a_bcd = 8'h12; bus.b_bcd = 8'h34; bus.op = OP_MUL; bus.start = 1'b1;
      begin
         exp_t x;
         x.res = 16'h0408; x.err = 1'b0; x.neg = 1'b0; x.lat = LAT_MDM;
         x.t0 = cyc + 1; x.name = "b2b_first";
         sb.push_back(x);
         x.t0 = cyc + 1 + LAT_MDM + 1; x.name = "b2b_second";
         sb.push_back(x);
      end
      repeat (LAT_MDM + 2) @(negedge clk);
      bus.start = 1'b0;
      drain();

      // Asynchronous reset in the middle of a multiply
      bus.a_bcd = 8'h99; bus.b_bcd = 8'h99; bus.op = OP_MUL; bus.start = 1'b1;
      t = cyc + 1;
      @(negedge clk);
      bus.start = 1'b0;
      while (cyc < t + 5) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("midreset.busy", 32'(bus.busy), 32'd0);
      chk("midreset.done", 32'(bus.done), 32'd0);
      chk("midreset.result", 32'(bus.result_bcd), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (30) @(negedge clk);
      chk("midreset.no_done_idle", 32'(bus.busy), 32'd0);
      issue(8'h25, 8'h04, OP_MUL, 16'h0100, 1'b0, 1'b0, LAT_MDM, "after_reset"); drain();

      // DIGITS=3 instance: 999*999
      @(negedge clk);
      bus3.a_bcd = 12'h999; bus3.b_bcd = 12'h999; bus3.op = OP_MUL; bus3.start = 1'b1;
      t = cyc + 1;
      @(negedge clk);
      bus3.start = 1'b0;
      n = 0;
      while (bus3.done !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         checks++;
         failures++;
         $display("FAIL d3_mul.timeout: actual=no_done required=done");
      end else begin
         chk("d3_mul.result", 32'(bus3.result_bcd), 32'h0099_8001);
         chk("d3_mul.err", 32'(bus3.err), 32'd0);
         chk("d3_mul.latency", 32'(cyc - t), 32'd33);
      end

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
